// File: rtl/nes_pkg.sv
// Shared constants, event layout and scan FSM encoding for the NES input sequencer.
package nes_pkg;

  // Button indices in the order the controller shifts them out
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Event word layout: {repeat, press, index}
  localparam int EV_REPEAT_BIT = 4;
  localparam int EV_PRESS_BIT  = 3;
  localparam int EV_IDX_MSB    = 2;
  localparam int EV_W          = EV_REPEAT_BIT + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_e;

  function automatic logic [EV_W-1:0] make_event(input logic rpt, input logic press,
                                                 input logic [EV_IDX_MSB:0] idx);
    make_event = {rpt, press, idx};
  endfunction

endpackage

// File: rtl/nes_event_fifo.sv
// Small first-word-fall-through FIFO; head word comes straight out of the storage registers.
module nes_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        pop_ok, push_ok;

  // A pop frees the head slot this cycle, so a push into a full FIFO is still accepted
  assign pop_ok  = pop & valid;
  assign push_ok = push & (~full | pop_ok);
  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nes_input_sequencer.sv
// Turns controller button frames into press/release/auto-repeat events for the CPU,
// with a stable button state, a link watchdog and a sticky overflow flag.
module nes_input_sequencer
  import nes_pkg::*;
#(
  parameter int         DEPTH        = 4,
  parameter int         TIMEOUT      = 100000,
  parameter int         REPEAT_DELAY = 300,
  parameter int         REPEAT_RATE  = 50,
  parameter logic [7:0] REPEAT_MASK  = 8'hF0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in_buttons,
  input  logic            in_ready,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EV_W-1:0] ev_data,
  output logic [7:0]      state,
  output logic            connected,
  output logic            overflow,
  input  logic            clear_overflow
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(RMAX + 1);
  localparam int WDW  = $clog2(TIMEOUT + 1);

  scan_state_e       fsm_q, fsm_d;
  logic [2:0]        idx_q;
  logic [7:0]        state_q, new_q, diff_q;
  logic              fire_q;
  logic              pend_vld;
  logic [7:0]        pend_data;
  logic [WDW-1:0]    wd_cnt;
  logic              wd_hit;
  logic              connected_q, overflow_q;
  logic [CW-1:0]     rpt_cnt, cnt_inc, cnt_d;
  logic              rpt_rate, rate_d, fire_d;
  logic [7:0]        frame, diff_d;
  logic              accept, synth;
  logic              push, fifo_full, pop;
  logic [EV_W-1:0]   ev_in;

  assign wd_hit = (wd_cnt == WDW'(TIMEOUT));
  assign pop    = ev_ready & ev_valid;

  // Scan state register
  always_ff @(posedge clk) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // Frame selection in IDLE (live > pending > synthetic release), event generation in SCAN
  always_comb begin
    fsm_d  = fsm_q;
    accept = 1'b0;
    synth  = 1'b0;
    frame  = 8'h00;
    push   = 1'b0;
    ev_in  = '0;
    case (fsm_q)
      S_IDLE: begin
        if (in_ready) begin
          accept = 1'b1;
          frame  = in_buttons;
        end else if (pend_vld) begin
          accept = 1'b1;
          frame  = pend_data;
        end else if (wd_hit && connected_q) begin
          accept = 1'b1;
          synth  = 1'b1;
        end
        if (accept) fsm_d = S_SCAN;
      end
      S_SCAN: begin
        if (diff_q[idx_q]) begin
          push  = 1'b1;
          ev_in = make_event(1'b0, new_q[idx_q], idx_q);
        end else if (fire_q && new_q[idx_q] && REPEAT_MASK[idx_q]) begin
          push  = 1'b1;
          ev_in = make_event(1'b1, 1'b1, idx_q);
        end
        if (idx_q == 3'd7) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Repeat poll counter update for the frame being accepted
  always_comb begin
    diff_d  = frame ^ state_q;
    cnt_inc = rpt_cnt + CW'(1);
    cnt_d   = cnt_inc;
    rate_d  = rpt_rate;
    fire_d  = 1'b0;
    if (diff_d != 8'h00 || (frame & REPEAT_MASK) == 8'h00) begin
      cnt_d  = '0;
      rate_d = 1'b0;
    end else if ((!rpt_rate && cnt_inc == CW'(REPEAT_DELAY)) ||
                 ( rpt_rate && cnt_inc == CW'(REPEAT_RATE))) begin
      fire_d = 1'b1;
      cnt_d  = '0;
      rate_d = 1'b1;
    end
  end

  // Frame capture, scan index, pending slot and repeat state
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      state_q     <= '0;
      new_q       <= '0;
      diff_q      <= '0;
      fire_q      <= 1'b0;
      pend_vld    <= 1'b0;
      pend_data   <= '0;
      rpt_cnt     <= '0;
      rpt_rate    <= 1'b0;
      connected_q <= 1'b0;
    end else begin
      if (fsm_q == S_SCAN) idx_q <= idx_q + 3'd1;
      if (accept) begin
        state_q     <= frame;
        new_q       <= frame;
        diff_q      <= diff_d;
        fire_q      <= fire_d;
        rpt_cnt     <= cnt_d;
        rpt_rate    <= rate_d;
        idx_q       <= '0;
        connected_q <= ~synth;
      end
      // Frames arriving mid-scan park here; a newer one overwrites an older one
      if (in_ready && fsm_q == S_SCAN) begin
        pend_vld  <= 1'b1;
        pend_data <= in_buttons;
      end else if (accept) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  // Watchdog: cycles since the last in_ready, saturating at TIMEOUT
  always_ff @(posedge clk) begin
    if (reset)        wd_cnt <= '0;
    else if (in_ready) wd_cnt <= '0;
    else if (!wd_hit)  wd_cnt <= wd_cnt + WDW'(1);
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset)                        overflow_q <= 1'b0;
    else if (push && fifo_full && !pop) overflow_q <= 1'b1;
    else if (clear_overflow)          overflow_q <= 1'b0;
  end

  nes_event_fifo #(.DEPTH(DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ev_in),
    .full  (fifo_full),
    .pop   (pop),
    .valid (ev_valid),
    .data  (ev_data)
  );

  assign state     = state_q;
  assign connected = connected_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nes_input_sequencer.sv
// Self-checking bench for nes_input_sequencer: directed scenarios plus randomized frames
// checked against a per-frame behavioural event model.
module tb_nes_input_sequencer;
  localparam int         TO = 50;
  localparam int         RD = 3;
  localparam int         RR = 2;
  localparam logic [7:0] RM = 8'hF0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_buttons = 8'h00;
  logic       in_ready = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       ev_valid;
  logic [4:0] ev_data;
  logic [7:0] state;
  logic       connected, overflow;

  int checks = 0;
  int failures = 0;

  logic [4:0] obs[$];
  logic [4:0] exp_q[$];

  // model state for the random test
  logic [7:0] m_state;
  int         m_cnt;
  bit         m_rate;

  always #5 clk = ~clk;

  nes_input_sequencer #(
    .DEPTH(4), .TIMEOUT(TO), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(RM)
  ) dut (
    .clk(clk), .reset(reset), .in_buttons(in_buttons), .in_ready(in_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .state(state),
    .connected(connected), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  // record every event the consumer takes
  always @(negedge clk)
    if (!reset && ev_valid === 1'b1 && ev_ready) obs.push_back(ev_data);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_ready = 1'b0; clear_overflow = 1'b0;
    tick(1);
    reset = 1'b0;
    obs.delete();
  endtask

  task automatic send(input logic [7:0] b);
    in_buttons = b; in_ready = 1'b1;
    tick(1);
    in_ready = 1'b0;
  endtask

  // expected events for one accepted frame, from the press/release/repeat rules
  task automatic model_frame(input logic [7:0] nw);
    logic [7:0] d;
    bit fire;
    d = nw ^ m_state;
    fire = 0;
    if (d != 8'h00 || (nw & RM) == 8'h00) begin
      m_cnt = 0; m_rate = 0;
    end else begin
      m_cnt++;
      if (m_cnt == (m_rate ? RR : RD)) begin fire = 1; m_cnt = 0; m_rate = 1; end
    end
    for (int i = 0; i < 8; i++) begin
      if (d[i])                        exp_q.push_back({1'b0, nw[i], 3'(i)});
      else if (fire && nw[i] && RM[i]) exp_q.push_back({1'b1, 1'b1, 3'(i)});
    end
    m_state = nw;
  endtask

  task automatic test_reset();
    tick(2);
    reset = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
    checks++; if (ev_data !== 5'h00) begin failures++; $display("FAIL reset_ev_data got %h want 00", ev_data); end
    checks++; if (state !== 8'h00) begin failures++; $display("FAIL reset_state got %h want 00", state); end
    checks++; if (connected !== 1'b0) begin failures++; $display("FAIL reset_connected got %b want 0", connected); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b want 0", overflow); end
    // reset in the middle of a scan
    ev_ready = 1'b0;
    send(8'hFF);
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++; if (ev_valid !== 1'b0 || state !== 8'h00 || connected !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL midscan_reset got valid=%b state=%h conn=%b ovf=%b want 0/00/0/0",
                           ev_valid, state, connected, overflow);
    end
    reset = 1'b0;
    tick(12);
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL midscan_no_partial got valid=%b want 0", ev_valid); end
  endtask

  task automatic test_press();
    do_reset(); ev_ready = 1'b1;
    send(8'h01); tick(10);
    send(8'h81); tick(10);
    exp_q = '{5'h08, 5'h0F};
    checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL press_count got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL press_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (state !== 8'h81) begin failures++; $display("FAIL press_state got %h want 81", state); end
    checks++; if (connected !== 1'b1) begin failures++; $display("FAIL press_connected got %b want 1", connected); end
  endtask

  task automatic test_release();
    do_reset(); ev_ready = 1'b1;
    send(8'h03); tick(10);
    send(8'h00); tick(10);
    exp_q = '{5'h08, 5'h09, 5'h00, 5'h01};
    checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL release_count got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL release_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_repeat();
    do_reset(); ev_ready = 1'b1;
    for (int p = 1; p <= 8; p++) begin
      send(8'h10); tick(10);
      if (p == 3) begin
        checks++; if (obs.size() != 1) begin failures++; $display("FAIL repeat_poll3_count got %0d want 1", obs.size()); end
      end
      if (p == 4) begin
        checks++; if (obs.size() != 2) begin failures++; $display("FAIL repeat_poll4_count got %0d want 2", obs.size()); end
      end
    end
    exp_q = '{5'h0C, 5'h1C, 5'h1C, 5'h1C};
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL repeat_hold_count got %0d want 4", obs.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL repeat_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    for (int p = 9; p <= 11; p++) begin send(8'h30); tick(10); end
    checks++; if (obs.size() != 5 || obs[4] !== 5'h0D) begin
      failures++; $display("FAIL repeat_change got count=%0d last=%h want 5/0D", obs.size(), obs[obs.size()-1]);
    end
    send(8'h30); tick(10);
    checks++; if (obs.size() != 7 || obs[5] !== 5'h1C || obs[6] !== 5'h1D) begin
      failures++; $display("FAIL repeat_after_change got count=%0d want 7 with 1C,1D", obs.size());
    end
  endtask

  task automatic test_overflow();
    do_reset(); ev_ready = 1'b0;
    send(8'hFF); tick(10);
    checks++; if (ev_valid !== 1'b1 || ev_data !== 5'h08) begin failures++; $display("FAIL ovf_head got valid=%b data=%h want 1/08", ev_valid, ev_data); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b want 1", overflow); end
    clear_overflow = 1'b1; tick(1); clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", overflow); end
    // clear held across every dropped push of the next frame
    send(8'h00);
    clear_overflow = 1'b1; tick(8); clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
    ev_ready = 1'b1; tick(6);
    exp_q = '{5'h08, 5'h09, 5'h0A, 5'h0B};
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL ovf_drain_count got %0d want 4", obs.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got %b want 0", ev_valid); end
  endtask

  task automatic test_pending();
    do_reset(); ev_ready = 1'b1;
    send(8'h01); tick(1);
    send(8'h02); tick(1);
    send(8'h04); tick(20);
    exp_q = '{5'h08, 5'h00, 5'h0A};
    checks++; if (obs.size() != 3) begin failures++; $display("FAIL pending_count got %0d want 3", obs.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL pending_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (state !== 8'h04) begin failures++; $display("FAIL pending_state got %h want 04", state); end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset(); ev_ready = 1'b1;
    send(8'h01); tick(39);
    checks++; if (connected !== 1'b1) begin failures++; $display("FAIL wd_still_connected got %b want 1", connected); end
    n = 0;
    while (connected !== 1'b0 && n < 40) begin tick(1); n++; end
    checks++; if (connected !== 1'b0) begin failures++; $display("FAIL wd_timeout got connected=%b want 0", connected); end
    checks++; if (state !== 8'h00) begin failures++; $display("FAIL wd_state got %h want 00", state); end
    tick(10);
    checks++; if (obs.size() != 2 || obs[1] !== 5'h00) begin failures++; $display("FAIL wd_release got count=%0d want 2 ending 00", obs.size()); end
    send(8'h01); tick(10);
    checks++; if (connected !== 1'b1) begin failures++; $display("FAIL wd_reconnect got %b want 1", connected); end
    checks++; if (obs.size() != 3 || obs[2] !== 5'h08) begin failures++; $display("FAIL wd_press got count=%0d want 3 ending 08", obs.size()); end
  endtask

  task automatic test_random();
    logic [7:0] cur;
    do_reset(); ev_ready = 1'b1;
    exp_q.delete();
    m_state = 8'h00; m_cnt = 0; m_rate = 0;
    cur = 8'h00;
    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    cur = cur;
        2:       cur = 8'($urandom);
        default: cur = cur ^ (8'h01 << $urandom_range(0, 7));
      endcase
      send(cur);
      model_frame(cur);
      tick($urandom_range(8, 12));
    end
    tick(12);
    checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand_ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    checks++; if (state !== m_state) begin failures++; $display("FAIL rand_state got %h want %h", state, m_state); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_repeat();
    test_overflow();
    test_pending();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
